// File: rtl/lpc_ringbuffer_ctrl.sv
// FIFO controller for the dual-port record buffer: combinational write port,
// read FSM that absorbs the RAM's registered read latency, and drop accounting.
module lpc_ringbuffer_ctrl #(
   parameter int AW = 8,
   parameter int DW = 8,
   parameter int CW = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          buf_wr_en,
   output logic [AW-1:0] buf_wr_addr,
   output logic [DW-1:0] buf_wr_data,
   output logic          buf_rd_en,
   output logic [AW-1:0] buf_rd_addr,
   input  logic [DW-1:0] buf_rd_data,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic [AW:0]   level,
   output logic          empty,
   output logic          full,
   output logic          overflow,
   output logic [CW-1:0] drop_count
);

   typedef enum logic [1:0] {IDLE, WAIT, VALID} state_t;

   localparam logic [AW:0]   FULL_LEVEL = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0]   PTR_ONE    = {{AW{1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};

   state_t        state_reg, state_next;
   logic [AW:0]   wptr_reg, rptr_reg;
   logic [DW-1:0] out_data_reg;
   logic          overflow_reg;
   logic [CW-1:0] drop_count_reg;

   logic [AW:0]   level_int;
   logic          full_int, empty_int;
   logic          wr_fire, drop_fire, rd_fire, capture;

   // Occupancy counts slots whose read has not yet been issued; the extra
   // pointer bit distinguishes full from empty.
   assign level_int = wptr_reg - rptr_reg;
   assign full_int  = (level_int == FULL_LEVEL);
   assign empty_int = (level_int == '0);

   // Upstream cannot be stalled, so a record arriving while full is dropped.
   assign wr_fire   = in_valid & ~full_int & ~reset;
   assign drop_fire = in_valid &  full_int & ~reset;

   // Read sequencing: issue from IDLE, wait one cycle for the RAM output
   // register, then hold the record until downstream accepts it.
   always_comb begin
      state_next = state_reg;
      rd_fire    = 1'b0;
      capture    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!empty_int) begin
               rd_fire    = 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            capture    = 1'b1;
            state_next = VALID;
         end
         VALID: begin
            if (out_ready) begin
               if (!empty_int) begin
                  rd_fire    = 1'b1;
                  state_next = WAIT;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      if (reset) begin
         rd_fire = 1'b0;
         capture = 1'b0;
      end
   end

   // State register for the read sequencer.
   always_ff @(posedge clock) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Pointers advance on the same edge as the RAM write / read-issue.
   always_ff @(posedge clock) begin
      if (reset) begin
         wptr_reg <= '0;
         rptr_reg <= '0;
      end else begin
         if (wr_fire) wptr_reg <= wptr_reg + PTR_ONE;
         if (rd_fire) rptr_reg <= rptr_reg + PTR_ONE;
      end
   end

   // Output record register, loaded from the RAM one cycle after the read.
   always_ff @(posedge clock) begin
      if (reset)        out_data_reg <= '0;
      else if (capture) out_data_reg <= buf_rd_data;
   end

   // Sticky overflow flag and saturating drop counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow_reg   <= 1'b0;
         drop_count_reg <= '0;
      end else if (drop_fire) begin
         overflow_reg <= 1'b1;
         if (drop_count_reg != '1) drop_count_reg <= drop_count_reg + CNT_ONE;
      end
   end

   assign buf_wr_en   = wr_fire;
   assign buf_wr_addr = wptr_reg[AW-1:0];
   assign buf_wr_data = in_data;
   assign buf_rd_en   = rd_fire;
   assign buf_rd_addr = rptr_reg[AW-1:0];
   assign out_valid   = (state_reg == VALID);
   assign out_data    = out_data_reg;
   assign level       = level_int;
   assign empty       = empty_int;
   assign full        = full_int;
   assign overflow    = overflow_reg;
   assign drop_count  = drop_count_reg;

endmodule

// File: tb/tb_lpc_ringbuffer_ctrl.sv
// Bench for lpc_ringbuffer_ctrl with a small depth and narrow drop counter,
// a behavioural RAM, and a queue-based occupancy/ordering reference.
module tb_lpc_ringbuffer_ctrl;

   localparam int AW    = 2;
   localparam int DW    = 8;
   localparam int CW    = 2;
   localparam int DEPTH = 4;
   localparam int CMAX  = 3;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          out_ready = 1'b0;
   logic          buf_wr_en, buf_rd_en;
   logic [AW-1:0] buf_wr_addr, buf_rd_addr;
   logic [DW-1:0] buf_wr_data, buf_rd_data, out_data;
   logic          out_valid, empty, full, overflow;
   logic [AW:0]   level;
   logic [CW-1:0] drop_count;

   int errors = 0;
   int checks = 0;

   lpc_ringbuffer_ctrl #(.AW(AW), .DW(DW), .CW(CW)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_data(in_data),
      .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
      .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .level(level), .empty(empty), .full(full),
      .overflow(overflow), .drop_count(drop_count)
   );

   always #5 clock = ~clock;

   // Behavioural dual-port buffer with registered read.
   logic [DW-1:0] ram [DEPTH];
   always @(posedge clock) begin
      if (buf_wr_en) ram[buf_wr_addr] <= buf_wr_data;
      if (buf_rd_en) buf_rd_data <= ram[buf_rd_addr];
   end

   // Reference: records in RAM not yet issued, one record in flight from the
   // RAM, one record presented downstream, plus an order scoreboard.
   logic [DW-1:0] m_ram_q[$];
   logic [DW-1:0] m_exp_q[$];
   logic          m_known = 1'b0;
   logic          m_fetch_valid, m_held_valid, m_overflow;
   logic [DW-1:0] m_fetch_data, m_out_data;
   int            m_drops;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic rdy, input logic rst);
      logic accept, issue, full_now;
      int   sz;
      in_valid  = iv;
      in_data   = d;
      out_ready = rdy;
      reset     = rst;
      @(negedge clock);
      if (m_known) begin
         sz       = m_ram_q.size();
         full_now = (sz == DEPTH);
         accept   = m_held_valid && rdy;
         issue    = (sz > 0) && ((!m_held_valid && !m_fetch_valid) || accept);
         check_eq("out_valid", 32'(out_valid), 32'(m_held_valid));
         check_eq("out_data", 32'(out_data), 32'(m_out_data));
         check_eq("level", 32'(level), 32'(sz));
         check_eq("empty", 32'(empty), 32'(sz == 0));
         check_eq("full", 32'(full), 32'(full_now));
         check_eq("overflow", 32'(overflow), 32'(m_overflow));
         check_eq("drop_count", 32'(drop_count), 32'(m_drops));
         check_eq("buf_wr_en", 32'(buf_wr_en), 32'(iv && !full_now && !rst));
         check_eq("buf_rd_en", 32'(buf_rd_en), 32'(issue && !rst));
         if (!rst) begin
            if (accept) begin
               if (m_exp_q.size() == 0) check_eq("spurious_accept", 32'(out_valid), 32'(0));
               else check_eq("order", 32'(out_data), 32'(m_exp_q.pop_front()));
               m_held_valid = 1'b0;
            end
            if (m_fetch_valid) begin
               m_out_data    = m_fetch_data;
               m_held_valid  = 1'b1;
               m_fetch_valid = 1'b0;
            end
            if (issue) begin
               m_fetch_data  = m_ram_q.pop_front();
               m_fetch_valid = 1'b1;
            end
            if (iv) begin
               if (full_now) begin
                  m_overflow = 1'b1;
                  if (m_drops < CMAX) m_drops++;
               end else begin
                  m_ram_q.push_back(d);
                  m_exp_q.push_back(d);
               end
            end
         end
      end
      if (rst) begin
         m_known       = 1'b1;
         m_ram_q.delete();
         m_exp_q.delete();
         m_fetch_valid = 1'b0;
         m_held_valid  = 1'b0;
         m_overflow    = 1'b0;
         m_out_data    = '0;
         m_fetch_data  = '0;
         m_drops       = 0;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      cycle(1'b0, '0, 1'b0, 1'b1);
   endtask

   initial begin
      do_reset();
      do_reset();

      // In-order delivery of three records with downstream always ready.
      cycle(1'b1, 8'h11, 1'b1, 1'b0);
      cycle(1'b1, 8'h22, 1'b1, 1'b0);
      cycle(1'b1, 8'h33, 1'b1, 1'b0);
      repeat (10) cycle(1'b0, '0, 1'b1, 1'b0);
      $display("t1 streamed 3 records, empty=%0d", empty);

      // Fill a stalled FIFO; sixth record dropped, then drain.
      do_reset();
      for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
      repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
      $display("t2 filled: full=%0d drop_count=%0d overflow=%0d", full, drop_count, overflow);
      repeat (14) cycle(1'b0, '0, 1'b1, 1'b0);

      // Backpressure with out_ready toggling every three clocks.
      do_reset();
      for (int i = 0; i < 40; i++)
         cycle((i < 20) && (i % 2 == 0), 8'(8'h30 + i), ((i / 3) % 2) == 1, 1'b0);
      repeat (10) cycle(1'b0, '0, 1'b1, 1'b0);
      $display("t3 backpressure burst done, drops=%0d", drop_count);

      // Twenty records at steady state, several pointer wraps.
      do_reset();
      for (int i = 0; i < 40; i++)
         cycle(i % 2 == 0, 8'(8'h50 + i / 2), 1'b1, 1'b0);
      repeat (6) cycle(1'b0, '0, 1'b1, 1'b0);
      check_eq("wrap_no_drop", 32'(drop_count), 32'(0));
      $display("t4 20-record stream done, empty=%0d", empty);

      // Saturating drop counter.
      do_reset();
      for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      check_eq("sat_drop_count", 32'(drop_count), 32'(CMAX));
      $display("t5 saturation: drop_count=%0d", drop_count);
      repeat (14) cycle(1'b0, '0, 1'b1, 1'b0);

      // Reset while a record is held and two remain in the RAM.
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
      repeat (2) cycle(1'b0, '0, 1'b0, 1'b0);
      check_eq("pre_reset_level", 32'(level), 32'(2));
      do_reset();
      cycle(1'b1, 8'h71, 1'b1, 1'b0);
      cycle(1'b1, 8'h72, 1'b1, 1'b0);
      repeat (8) cycle(1'b0, '0, 1'b1, 1'b0);
      $display("t6 mid-handshake reset recovered, empty=%0d", empty);

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
               $urandom_range(0, 99) == 0);
      repeat (12) cycle(1'b0, '0, 1'b1, 1'b0);
      $display("t7 random traffic done");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
